mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/esn_pkg.sv | 22 ++
 rtl/multy.sv | 21 ++
 rtl/mac_sequencer.sv | 143 ++++++++++++++
 tb/tb_mac_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/esn_pkg.sv
// Shared FSM encodings and two's-complement saturation limits for the MAC datapath.
package esn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SAT_MAX_W = 64;

    // Limits are returned 64 bits wide; callers truncate to their accumulator width.
    function automatic logic [SAT_MAX_W-1:0] sat_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_neg(input int w);
        return ~sat_pos(w);
    endfunction

endpackage

// File: rtl/multy.sv
// Combinational sign-magnitude multiplier: product is {signA^signB, |A|*|B|}.
// Zero latency, no flow control; a zero magnitude may carry either sign.
module multy #(
    parameter int demention_dataa = 8,
    parameter int demention_datab = 8
) (
    input  logic [demention_dataa-1:0]                 dataa_i,
    input  logic [demention_datab-1:0]                 datab_i,
    output logic [demention_dataa+demention_datab-2:0] product_o
);

    localparam int MAG_W = demention_dataa + demention_datab - 2;

    logic [MAG_W-1:0] mag;

    always_comb begin
        mag       = MAG_W'(dataa_i[demention_dataa-2:0]) * MAG_W'(datab_i[demention_datab-2:0]);
        product_o = {dataa_i[demention_dataa-1] ^ datab_i[demention_datab-1], mag};
    end

endmodule

// File: rtl/mac_sequencer.sv
// Sequenced sign-magnitude dot product with saturating two's-complement accumulator.
// Result pulses L+2 cycles after start (1 for L=0); starts are ignored while busy.
module mac_sequencer
    import esn_pkg::*;
#(
    parameter int demention_data = 8,
    parameter int demention_acc  = 24,
    parameter int demention_len  = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iStart,
    input  logic [demention_len-1:0]  iLength,
    output logic                      oRdEn,
    output logic [demention_len-1:0]  oAddr,
    input  logic [demention_data-1:0] iDataa,
    input  logic [demention_data-1:0] iDatab,
    output logic                      oBusy,
    output logic                      oValid,
    output logic [demention_acc-1:0]  oResult,
    output logic                      oOverflow
);

    localparam int PROD_W = 2 * demention_data - 1;
    localparam int MAG_W  = PROD_W - 1;
    localparam logic [demention_acc-1:0] SAT_POS = demention_acc'(sat_pos(demention_acc));
    localparam logic [demention_acc-1:0] SAT_NEG = demention_acc'(sat_neg(demention_acc));

    state_t                     state_q, state_d;
    logic [demention_len-1:0]   len_q, len_d;
    logic [demention_len-1:0]   addr_q, addr_d;
    logic                       drain_q, drain_d;
    logic                       data_vld_q;
    logic                       prod_vld_q;
    logic [PROD_W-1:0]          prod_q;
    logic [demention_acc-1:0]   acc_q, acc_d;
    logic [demention_acc-1:0]   result_q, result_d;
    logic                       ovf_q, ovf_d;

    logic                       accept;
    logic [PROD_W-1:0]          sm_prod;
    logic [PROD_W-1:0]          prod_tc;
    logic [demention_acc-1:0]   prod_ext;
    logic [demention_acc:0]     sum;

    multy #(
        .demention_dataa (demention_data),
        .demention_datab (demention_data)
    ) u_multy (
        .dataa_i   (iDataa),
        .datab_i   (iDatab),
        .product_o (sm_prod)
    );

    assign accept = (state_q == ST_IDLE) && iStart;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An empty vector skips RUN and enters the last DRAIN cycle directly.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (iStart) state_d = (iLength == '0) ? ST_DRAIN : ST_RUN;
            ST_RUN:   if (addr_q == len_q - demention_len'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        oRdEn     = (state_q == ST_RUN);
        oAddr     = oRdEn ? addr_q : '0;
        oBusy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        oValid    = (state_q == ST_DONE);
        oResult   = result_q;
        oOverflow = ovf_q;
    end

    always_comb begin
        len_d   = accept ? iLength : len_q;
        addr_d  = ((state_q == ST_RUN) && (state_d == ST_RUN)) ? addr_q + demention_len'(1) : '0;
        drain_d = (state_q == ST_DRAIN) || (accept && (iLength == '0));
    end

    // Zero magnitude maps to +0 so a "-0" operand never perturbs the sum.
    always_comb begin
        prod_tc = '0;
        if (sm_prod[MAG_W-1:0] != '0) begin
            prod_tc = sm_prod[PROD_W-1] ? -{1'b0, sm_prod[MAG_W-1:0]} : {1'b0, sm_prod[MAG_W-1:0]};
        end
    end

    always_comb begin
        prod_ext = {{(demention_acc - PROD_W){prod_q[PROD_W-1]}}, prod_q};
        sum      = {acc_q[demention_acc-1], acc_q} + {prod_ext[demention_acc-1], prod_ext};
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (accept) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            if (sum[demention_acc] != sum[demention_acc-1]) begin
                acc_d = sum[demention_acc] ? SAT_NEG : SAT_POS;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum[demention_acc-1:0];
            end
        end
        result_d = ((state_q == ST_DRAIN) && (state_d == ST_DONE)) ? acc_d : result_q;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            len_q      <= '0;
            addr_q     <= '0;
            drain_q    <= 1'b0;
            data_vld_q <= 1'b0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            len_q      <= len_d;
            addr_q     <= addr_d;
            drain_q    <= drain_d;
            data_vld_q <= oRdEn;
            prod_vld_q <= data_vld_q;
            prod_q     <= data_vld_q ? prod_tc : '0;
            acc_q      <= acc_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench: two instances (24-bit and 16-bit accumulators) share stimulus and operand memory.
module tb_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  da, db;
    logic        rd24, rd16, busy24, busy16, vld24, vld16, ovf24, ovf16;
    logic [7:0]  addr24, addr16;
    logic [23:0] res24;
    logic [15:0] res16;

    always #5 clk = ~clk;

    mac_sequencer #(.demention_data(8), .demention_acc(24), .demention_len(8)) dut (
        .iClk(clk), .iRst(rst), .iStart(start), .iLength(len),
        .oRdEn(rd24), .oAddr(addr24), .iDataa(da), .iDatab(db),
        .oBusy(busy24), .oValid(vld24), .oResult(res24), .oOverflow(ovf24)
    );

    mac_sequencer #(.demention_data(8), .demention_acc(16), .demention_len(8)) dut16 (
        .iClk(clk), .iRst(rst), .iStart(start), .iLength(len),
        .oRdEn(rd16), .oAddr(addr16), .iDataa(da), .iDatab(db),
        .oBusy(busy16), .oValid(vld16), .oResult(res16), .oOverflow(ovf16)
    );

    typedef struct {
        int          len;
        int          start_cyc;
        logic [23:0] r24;
        logic        o24;
        logic [15:0] r16;
        logic        o16;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Operand memory: data for a read strobe appears one cycle later; garbage otherwise.
    logic       rd_p = 1'b0;
    logic [7:0] addr_p = 8'd0;
    always @(posedge clk) begin
        #1;
        if (rd_p) begin
            da = mem_a[addr_p];
            db = mem_b[addr_p];
        end else begin
            da = 8'($urandom);
            db = 8'($urandom);
        end
        rd_p   = rd24;
        addr_p = addr24;
    end

    int rd_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            rd_cnt = 0;
        end else begin
            if (rd24) begin
                check("rd_addr24", 32'(addr24), rd_cnt);
                check("rd_addr16", 32'(addr16), rd_cnt);
                check("rd_en16", 32'(rd16), 32'd1);
                rd_cnt++;
            end else begin
                check("idle_addr24", 32'(addr24), 32'd0);
                check("idle_rd16", 32'(rd16), 32'd0);
            end
            if (vld24 || vld16) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got valid24=%0b valid16=%0b, expected none (cycle %0d)", vld24, vld16, cyc);
                end else begin
                    e = sb.pop_front();
                    check("valid24", 32'(vld24), 32'd1);
                    check("valid16", 32'(vld16), 32'd1);
                    check("result24", 32'(res24), 32'(e.r24));
                    check("ovf24", 32'(ovf24), 32'(e.o24));
                    check("result16", 32'(res16), 32'(e.r16));
                    check("ovf16", 32'(ovf16), 32'(e.o16));
                    check("latency", cyc - e.start_cyc, (e.len == 0) ? 1 : e.len + 2);
                    check("read_count", rd_cnt, e.len);
                    check("busy_at_valid", 32'({busy24, busy16}), 32'd0);
                end
                rd_cnt = 0;
            end else if (sb.size() != 0) begin
                check("busy_in_run", 32'({busy24, busy16}), 32'd3);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_res24"}, 32'(res24), 32'd0);
        check({tag, "_res16"}, 32'(res16), 32'd0);
        check({tag, "_ctl24"}, 32'({rd24, addr24, busy24, vld24, ovf24}), 32'd0);
        check({tag, "_ctl16"}, 32'({rd16, addr16, busy16, vld16, ovf16}), 32'd0);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] b);
        for (int k = 0; k < 8; k++) begin
            mem_a[k] = a[8*k +: 8];
            mem_b[k] = b[8*k +: 8];
        end
    endtask

    task automatic issue(input int l, input logic [23:0] r24, input logic o24,
                         input logic [15:0] r16, input logic o16);
        exp_t e;
        @(negedge clk);
        #1;
        start = 1'b1;
        len   = 8'(l);
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = 8'($urandom);
        e.len = l; e.start_cyc = cyc;
        e.r24 = r24; e.o24 = o24; e.r16 = r16; e.o16 = o16;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_%s: got no valid in 200 cycles, expected one", tag);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run(input string tag, input int l, input logic [63:0] a, input logic [63:0] b,
                       input logic [23:0] r24, input logic o24, input logic [15:0] r16, input logic o16,
                       input bit repulse);
        load(a, b);
        issue(l, r24, o24, r16, o16);
        if (repulse) begin
            @(negedge clk);
            #1;
            start = 1'b1;
            len   = 8'd1;
            @(negedge clk);
            #1;
            start = 1'b0;
        end
        wait_done(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no summary, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        len   = 8'd3;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);

        // 12 - 10 - 16129 = -16127
        run("mixed",    3, 64'h7F_85_03, 64'hFF_02_04, 24'hFFC101, 1'b0, 16'hC101, 1'b0, 1'b0);
        // 12 - 10 - 127 = -125
        run("mixed_m1", 3, 64'h7F_85_03, 64'h81_02_04, 24'hFFFF83, 1'b0, 16'hFF83, 1'b0, 1'b0);
        // 3 * 16129 = 48387 overflows only the 16-bit accumulator
        run("sat_pos",  3, 64'h7F_7F_7F, 64'h7F_7F_7F, 24'h00BD03, 1'b0, 16'h7FFF, 1'b1, 1'b0);
        run("sat_neg",  3, 64'h7F_7F_7F, 64'hFF_FF_FF, 24'hFF42FD, 1'b0, 16'h8000, 1'b1, 1'b0);
        run("neg_zero", 1, 64'h80, 64'h05, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0);
        run("len0",     0, 64'h7F, 64'h7F, 24'h000000, 1'b0, 16'h0000, 1'b0, 1'b0);
        // (-5)(-5) + (-6)(3) = 7
        run("signs",    2, 64'h86_85, 64'h03_85, 24'h000007, 1'b0, 16'h0007, 1'b0, 1'b0);
        // 1-2+3-4+5-6+7-8 = -4
        run("len8",     8, 64'h0807060504030201, 64'h8101810181018101,
            24'hFFFFFC, 1'b0, 16'hFFFC, 1'b0, 1'b0);
        // 16-bit: saturates at 32767 then drops by 16129 to 16638; flag stays set
        run("repulse",  4, 64'h7F7F7F7F, 64'hFF7F7F7F, 24'h007E02, 1'b0, 16'h40FE, 1'b1, 1'b1);

        // Reset sampled at edge E+2 of a 4-element run discards it.
        load(64'h7F7F7F7F, 64'h7F7F7F7F);
        issue(4, 24'h0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_zero("midrun_rst");
        sb.delete();
        rst = 1'b0;
        repeat (12) @(negedge clk);

        run("after_rst", 3, 64'h7F_85_03, 64'hFF_02_04, 24'hFFC101, 1'b0, 16'hC101, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
